// File: rtl/data_sram_bridge.sv
// Core memory-stage data port to split-handshake SRAM bus bridge; one access in flight, stalls core until done.
// Optional misaligned-access suppression: define DATA_BRIDGE_ALIGN_CHECK_EN.
module data_sram_bridge #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                cpu_en,
  input  logic                cpu_wr,
  input  logic [1:0]          cpu_size,
  input  logic [DATA_W/8-1:0] cpu_sel,
  input  logic [ADDR_W-1:0]   cpu_addr,
  input  logic [DATA_W-1:0]   cpu_wdata,
  input  logic                cpu_longstall,
  output logic [DATA_W-1:0]   cpu_rdata,
  output logic                cpu_stall,
  output logic                cpu_addr_err,
  output logic                bus_req,
  output logic                bus_wr,
  output logic [1:0]          bus_size,
  output logic [DATA_W/8-1:0] bus_wstrb,
  output logic [ADDR_W-1:0]   bus_addr,
  output logic [DATA_W-1:0]   bus_wdata,
  input  logic                bus_addr_ok,
  input  logic                bus_data_ok,
  input  logic [DATA_W-1:0]   bus_rdata
);

  localparam int STRB_W = DATA_W / 8;

  typedef enum logic [1:0] {IDLE, REQ, WAIT, DONE} state_t;

  state_t              r_state;
  state_t              w_next;
  logic                r_wr;
  logic [1:0]          r_size;
  logic [STRB_W-1:0]   r_wstrb;
  logic [ADDR_W-1:0]   r_addr;
  logic [DATA_W-1:0]   r_wdata;
  logic [DATA_W-1:0]   r_rdata;
  logic                w_misalign;
  logic                w_suppress;
  logic                w_start;
  logic                w_resp;

  always_comb begin
`ifdef DATA_BRIDGE_ALIGN_CHECK_EN
    w_misalign = ((cpu_size == 2'd1) & cpu_addr[0]) |
                 ((cpu_size >= 2'd2) & (cpu_addr[1:0] != 2'b00));
`else
    w_misalign = 1'b0;
`endif
  end

  assign w_suppress = cpu_en & w_misalign & (r_state == IDLE);
  assign w_start    = cpu_en & ~w_misalign & (r_state == IDLE);
  // data_ok only counts once the request has been accepted
  assign w_resp     = bus_data_ok & (((r_state == REQ) & bus_addr_ok) | (r_state == WAIT));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      IDLE: if (w_start) w_next = REQ;
      REQ:  if (bus_addr_ok) w_next = bus_data_ok ? DONE : WAIT;
      WAIT: if (bus_data_ok) w_next = DONE;
      DONE: if (!cpu_longstall) w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  always_comb begin
    bus_req      = (r_state == REQ);
    cpu_stall    = ~rst & cpu_en & ~w_suppress & (r_state != DONE);
    cpu_addr_err = ~rst & w_suppress;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wr    <= 1'b0;
      r_size  <= 2'd0;
      r_wstrb <= '0;
      r_addr  <= '0;
      r_wdata <= '0;
      r_rdata <= '0;
    end else begin
      if (w_start) begin
        r_wr    <= cpu_wr;
        r_size  <= (cpu_size == 2'd3) ? 2'd2 : cpu_size;
        r_wstrb <= cpu_wr ? cpu_sel : '0;
        r_addr  <= cpu_addr;
        r_wdata <= cpu_wdata;
      end
      if (w_resp && !r_wr) r_rdata <= bus_rdata;
    end
  end

  assign bus_wr    = r_wr;
  assign bus_size  = r_size;
  assign bus_wstrb = r_wstrb;
  assign bus_addr  = r_addr;
  assign bus_wdata = r_wdata;
  assign cpu_rdata = r_rdata;

endmodule

// File: tb/tb_data_sram_bridge.sv
// Scoreboard bench for data_sram_bridge: bus responder with programmable addr_ok/data_ok latency.
module tb_data_sram_bridge;

  logic        clk = 1'b0;
  logic        rst;
  logic        cpu_en, cpu_wr, cpu_longstall;
  logic [1:0]  cpu_size;
  logic [3:0]  cpu_sel;
  logic [31:0] cpu_addr, cpu_wdata;
  logic [31:0] cpu_rdata;
  logic        cpu_stall, cpu_addr_err;
  logic        bus_req, bus_wr;
  logic [1:0]  bus_size;
  logic [3:0]  bus_wstrb;
  logic [31:0] bus_addr, bus_wdata;
  logic        bus_addr_ok, bus_data_ok;
  logic [31:0] bus_rdata;

  typedef struct {
    logic        wr;
    logic [1:0]  size;
    logic [3:0]  strb;
    logic [31:0] addr;
    logic [31:0] wdata;
  } req_t;

  req_t        exp_q[$];
  logic [31:0] rd_q[$];
  logic [31:0] model_rdata;
  int unsigned n_checks = 0;
  int unsigned n_fail   = 0;

  always #5 clk = ~clk;

  data_sram_bridge #(.ADDR_W(32), .DATA_W(32)) dut (
    .clk(clk), .rst(rst),
    .cpu_en(cpu_en), .cpu_wr(cpu_wr), .cpu_size(cpu_size), .cpu_sel(cpu_sel),
    .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata), .cpu_longstall(cpu_longstall),
    .cpu_rdata(cpu_rdata), .cpu_stall(cpu_stall), .cpu_addr_err(cpu_addr_err),
    .bus_req(bus_req), .bus_wr(bus_wr), .bus_size(bus_size), .bus_wstrb(bus_wstrb),
    .bus_addr(bus_addr), .bus_wdata(bus_wdata),
    .bus_addr_ok(bus_addr_ok), .bus_data_ok(bus_data_ok), .bus_rdata(bus_rdata)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // One access; alat = REQ cycles before addr_ok, dlat = WAIT cycles before data_ok, ls = DONE cycles under longstall.
  task automatic access(input logic wr, input logic [1:0] size, input logic [3:0] sel,
                        input logic [31:0] addr, input logic [31:0] wdata, input logic [31:0] rsp,
                        input int unsigned alat, input int unsigned dlat, input int unsigned ls);
    req_t        e;
    req_t        got;
    int unsigned cyc = 0, stalls = 0, reqs = 0, waitc = 0;
    bit          accepted = 0, responded = 0, done = 0;
    logic [31:0] held;
    @(negedge clk);
    cpu_en = 1'b1; cpu_wr = wr; cpu_size = size; cpu_sel = sel;
    cpu_addr = addr; cpu_wdata = wdata; cpu_longstall = 1'b0;
    e.wr = wr; e.size = (size == 2'd3) ? 2'd2 : size; e.strb = wr ? sel : 4'h0;
    e.addr = addr; e.wdata = wdata;
    exp_q.push_back(e);
    if (!wr) model_rdata = rsp;
    rd_q.push_back(model_rdata);
    #1;
    check("addr_err", {31'd0, cpu_addr_err}, 32'd0);
    while (!done && cyc < 64) begin
      if (cyc != 0) #1;
      if (cpu_stall) stalls++;
      if (responded && !cpu_stall) done = 1;
      else begin
        if (bus_req) begin
          check("strb_hold", {28'd0, bus_wstrb}, {28'd0, e.strb});
          if (reqs == alat) begin
            bus_addr_ok = 1'b1;
            accepted = 1;
            if (exp_q.size() == 0) check("sb_empty", 32'd1, 32'd0);
            else begin
              got = exp_q.pop_front();
              check("bus_addr",  bus_addr, got.addr);
              check("bus_wr",    {31'd0, bus_wr}, {31'd0, got.wr});
              check("bus_size",  {30'd0, bus_size}, {30'd0, got.size});
              check("bus_wstrb", {28'd0, bus_wstrb}, {28'd0, got.strb});
              check("bus_wdata", bus_wdata, got.wdata);
            end
            if (dlat == 0) begin
              bus_data_ok = 1'b1; bus_rdata = rsp; responded = 1;
            end
          end
          reqs++;
        end else if (accepted && !responded) begin
          waitc++;
          if (waitc == dlat) begin
            bus_data_ok = 1'b1; bus_rdata = rsp; responded = 1;
          end
        end
        if (bus_data_ok && ls > 0) cpu_longstall = 1'b1;
        @(negedge clk);
        bus_addr_ok = 1'b0; bus_data_ok = 1'b0; bus_rdata = $urandom;
        cyc++;
      end
    end
    check("complete", {31'd0, done}, 32'd1);
    check("stall_cycles", stalls, 1 + (alat + 1) + dlat);
    check("req_cycles", reqs, alat + 1);
    check("done_req", {31'd0, bus_req}, 32'd0);
    held = rd_q.pop_front();
    check("cpu_rdata", cpu_rdata, held);
    for (int i = 1; i < int'(ls); i++) begin
      @(negedge clk); #1;
      check("ls_stall", {31'd0, cpu_stall}, 32'd0);
      check("ls_req",   {31'd0, bus_req}, 32'd0);
      check("ls_rdata", cpu_rdata, held);
    end
    cpu_longstall = 1'b0;
    cpu_en = 1'b0;
  endtask

  initial begin
    rst = 1'b1; cpu_en = 1'b1; cpu_wr = 1'b0; cpu_size = 2'd2; cpu_sel = 4'h0;
    cpu_addr = 32'h0; cpu_wdata = 32'h0; cpu_longstall = 1'b0;
    bus_addr_ok = 1'b0; bus_data_ok = 1'b0; bus_rdata = 32'h0;
    model_rdata = 32'h0;
    #2;
    check("rst_req",   {31'd0, bus_req}, 32'd0);
    check("rst_stall", {31'd0, cpu_stall}, 32'd0);
    check("rst_rdata", cpu_rdata, 32'd0);
    check("rst_addr",  bus_addr, 32'd0);
    check("rst_err",   {31'd0, cpu_addr_err}, 32'd0);
    @(negedge clk); cpu_en = 1'b0;
    @(negedge clk); rst = 1'b0;

    access(1'b0, 2'd2, 4'h0, 32'h0000_1000, 32'h0, 32'hDEAD_BEEF, 0, 0, 0);
    access(1'b1, 2'd2, 4'b0011, 32'h0000_2004, 32'h1234_5678, 32'hFFFF_FFFF, 2, 2, 0);
    access(1'b0, 2'd2, 4'h0, 32'h0000_3000, 32'h0, 32'hCAFE_F00D, 0, 1, 4);
    access(1'b0, 2'd2, 4'h0, 32'h0000_0010, 32'h0, 32'h1111_1111, 1, 0, 0);
    access(1'b0, 2'd2, 4'h0, 32'h0000_0014, 32'h0, 32'h2222_2222, 0, 3, 0);
    access(1'b1, 2'd3, 4'b1111, 32'h0000_0040, 32'hA5A5_5A5A, 32'h0, 0, 0, 0);
    access(1'b1, 2'd1, 4'b1100, 32'h0000_0042, 32'h00BB_0000, 32'h0, 1, 1, 0);

    // reset while waiting for data_ok
    @(negedge clk);
    cpu_en = 1'b1; cpu_wr = 1'b0; cpu_size = 2'd2; cpu_addr = 32'h0000_0500;
    @(negedge clk); #1;
    check("mid_req", {31'd0, bus_req}, 32'd1);
    bus_addr_ok = 1'b1;
    @(negedge clk); bus_addr_ok = 1'b0; #1;
    check("mid_wait_req",   {31'd0, bus_req}, 32'd0);
    check("mid_wait_stall", {31'd0, cpu_stall}, 32'd1);
    #1 rst = 1'b1; model_rdata = 32'h0;
    #1;
    check("arst_req",   {31'd0, bus_req}, 32'd0);
    check("arst_stall", {31'd0, cpu_stall}, 32'd0);
    check("arst_rdata", cpu_rdata, 32'd0);
    check("arst_addr",  bus_addr, 32'd0);
    cpu_en = 1'b0;
    @(negedge clk); rst = 1'b0;
    access(1'b0, 2'd2, 4'h0, 32'h0000_0600, 32'h0, 32'h0BAD_CAFE, 0, 0, 0);

`ifdef DATA_BRIDGE_ALIGN_CHECK_EN
    @(negedge clk);
    cpu_en = 1'b1; cpu_wr = 1'b0; cpu_size = 2'd2; cpu_addr = 32'h0000_1002;
    for (int i = 0; i < 3; i++) begin
      #1;
      check("mis_err",   {31'd0, cpu_addr_err}, 32'd1);
      check("mis_req",   {31'd0, bus_req}, 32'd0);
      check("mis_stall", {31'd0, cpu_stall}, 32'd0);
      @(negedge clk);
    end
    cpu_en = 1'b0;
    check("mis_rdata", cpu_rdata, 32'h0BAD_CAFE);
`else
    access(1'b0, 2'd2, 4'h0, 32'h0000_1002, 32'h0, 32'h5A5A_5A5A, 0, 0, 0);
`endif

    repeat (2) @(negedge clk);
    check("sb_drained", exp_q.size(), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
